// File: rtl/imem_uart_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_uart_loader_pkg
//  Purpose  : Shared definitions for the UART program-image loader: FSM state
//             encoding, default frame marker/reply bytes and frame field widths.
//  Revision : 1.0 - initial release
// ============================================================================
package imem_uart_loader_pkg;

  // Frame field widths
  localparam int unsigned c_BYTE_W = 8;
  localparam int unsigned c_WORD_W = 32;
  localparam int unsigned c_LEN_W  = 16;

  // Default protocol bytes
  localparam logic [7:0] c_MAGIC_DEFAULT = 8'hA5;
  localparam logic [7:0] c_ACK_DEFAULT   = 8'h5A;
  localparam logic [7:0] c_NAK_DEFAULT   = 8'hEE;

  // Loader FSM states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_SEND   = 3'd5,
    S_RUN    = 3'd6
  } state_t;

endpackage : imem_uart_loader_pkg
`default_nettype wire

// File: rtl/imem_uart_loader_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module   : loader_timeout_counter
//  Purpose  : Idle-cycle watchdog for UART byte streams. Counts enabled cycles
//             since the last clear and flags expiry at COUNT_MAX. Saturates.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             i_clear       - restart the count (takes priority over enable)
//             i_enable      - count this cycle
//             o_expired     - count has reached COUNT_MAX
//  Revision : 1.0 - initial release
// ============================================================================
module loader_timeout_counter #(
  parameter int unsigned COUNT_MAX = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned c_CW = $clog2(COUNT_MAX + 1);

  logic [c_CW-1:0] r_count;

  assign o_expired = (r_count >= c_CW'(COUNT_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + c_CW'(1);
    end
  end

endmodule : loader_timeout_counter
`default_nettype wire

// File: rtl/imem_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_uart_loader
//  Purpose  : Receives a framed program image over UART, assembles big-endian
//             32-bit words, writes them into instruction memory and holds the
//             CPU in reset until a good image is loaded; replies ACK/NAK.
//             Frame: MAGIC, N_hi, N_lo, 4*N data bytes, XOR checksum.
//  Ports    : clk, rst               - clock, asynchronous active-high reset
//             rx_data/rx_valid       - received byte and its strobe
//             tx_busy                - UART transmitter busy
//             tx_data/tx_start       - reply byte and one-cycle send request
//             imem_we/addr/wdata     - instruction memory write port
//             cpu_rst                - pipeline reset, high unless running
//             loading                - a load is in progress
//             error                  - sticky error of the last load attempt
//  Revision : 1.0 - initial release
// ============================================================================
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter logic [7:0]  MAGIC          = c_MAGIC_DEFAULT,
  parameter logic [7:0]  ACK_BYTE       = c_ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE       = c_NAK_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  loading,
  output logic                  error
);

  localparam int unsigned c_DEPTH = 32'd1 << ADDR_WIDTH;

  state_t               r_state;
  logic [c_LEN_W-1:0]   r_len;
  logic [c_LEN_W-1:0]   r_word_idx;
  logic [1:0]           r_byte_cnt;
  logic [23:0]          r_asm;      // top three bytes of the word in progress
  logic [7:0]           r_csum;
  logic                 r_len_err;
  logic                 r_good;

  logic                 w_tmo_en;
  logic                 w_tmo_clr;
  logic                 w_expired;
  logic [c_LEN_W-1:0]   w_len;
  logic                 w_csum_ok;
  logic                 w_in_range;

  // Watchdog only runs while waiting for frame bytes; SEND waits on tx_busy
  // and is deliberately not bounded by it.
  assign w_tmo_en  = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                     (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_tmo_clr = rx_valid || !w_tmo_en;

  assign w_len      = {r_len[15:8], rx_data};
  assign w_csum_ok  = (rx_data == r_csum) && !r_len_err;
  assign w_in_range = (32'(r_word_idx) < c_DEPTH);

  loader_timeout_counter #(
    .COUNT_MAX (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_tmo_clr),
    .i_enable  (w_tmo_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_csum     <= '0;
      r_len_err  <= 1'b0;
      r_good     <= 1'b0;
      cpu_rst    <= 1'b1;
      loading    <= 1'b0;
      error      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
    end else begin
      imem_we  <= 1'b0;
      tx_start <= 1'b0;

      if (w_tmo_en && w_expired) begin
        // Stalled sender: abandon silently, any partial word is dropped.
        r_state <= S_IDLE;
        error   <= 1'b1;
        loading <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_RUN: begin
            if (rx_valid && (rx_data == MAGIC)) begin
              r_state    <= S_LEN_HI;
              cpu_rst    <= 1'b1;
              loading    <= 1'b1;
              error      <= 1'b0;
              r_csum     <= '0;
              r_word_idx <= '0;
              r_byte_cnt <= '0;
              r_len_err  <= 1'b0;
            end
          end

          S_LEN_HI: begin
            if (rx_valid) begin
              r_len[15:8] <= rx_data;
              r_state     <= S_LEN_LO;
            end
          end

          S_LEN_LO: begin
            if (rx_valid) begin
              r_len     <= w_len;
              r_len_err <= (32'(w_len) > c_DEPTH);
              r_state   <= (w_len == '0) ? S_CSUM : S_DATA;
            end
          end

          S_DATA: begin
            if (rx_valid) begin
              r_asm      <= {r_asm[15:0], rx_data};
              r_csum     <= r_csum ^ rx_data;
              r_byte_cnt <= r_byte_cnt + 2'd1;
              if (r_byte_cnt == 2'd3) begin
                // Words past the memory depth are consumed but not written.
                if (w_in_range) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                  imem_wdata <= {r_asm, rx_data};
                end
                r_word_idx <= r_word_idx + c_LEN_W'(1);
                if (r_word_idx == (r_len - c_LEN_W'(1))) begin
                  r_state <= S_CSUM;
                end
              end
            end
          end

          S_CSUM: begin
            if (rx_valid) begin
              r_good  <= w_csum_ok;
              error   <= !w_csum_ok;
              tx_data <= w_csum_ok ? ACK_BYTE : NAK_BYTE;
              r_state <= S_SEND;
            end
          end

          S_SEND: begin
            if (!tx_busy) begin
              tx_start <= 1'b1;
              loading  <= 1'b0;
              if (r_good) begin
                r_state <= S_RUN;
                cpu_rst <= 1'b0;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
            cpu_rst <= 1'b1;
            loading <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : imem_uart_loader
`default_nettype wire
